// File: rtl/if_id_pipe_reg_pkg.sv
// if_id_pipe_reg_pkg: shared fetch/decode widths, bubble encoding and fetch payload type.
package if_id_pipe_reg_pkg;
   localparam int XLEN = 64;
   localparam int INST_W = 32;
   localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;
   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [INST_W-1:0] inst;
   } fetch_t;
endpackage

// File: rtl/if_id_pipe_reg_skid_entry.sv
// pipe_skid_entry: one valid+payload register with load and clear (clear wins).
module pipe_skid_entry #(
   parameter int W = 96
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic         valid,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         valid <= 1'b0;
         q     <= '0;
      end else if (clr) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         q     <= d;
      end
endmodule

// File: rtl/if_id_pipe_reg.sv
// if_id_pipe_reg: IF/ID register with one-entry skid; priority flush > stall > advance.
// Optional perf counters enabled by defining IF_ID_PERF_EN.
module if_id_pipe_reg
   import if_id_pipe_reg_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_valid,
   input  logic [XLEN-1:0]   if_pc,
   input  logic [INST_W-1:0] if_inst,
   output logic              if_ready,
   input  logic              if_id_stall,
   input  logic              id_flush,
   output logic              id_valid,
   output logic [XLEN-1:0]   id_pc,
`ifdef IF_ID_PERF_EN
   output logic [31:0]       perf_stall_cnt,
   output logic [31:0]       perf_flush_cnt,
`endif
   output logic [INST_W-1:0] id_inst
);
   fetch_t sk_q;
   logic sk_valid, accept, hold, sk_load, sk_clr, id_valid_n;
   logic [XLEN-1:0] id_pc_n;
   logic [INST_W-1:0] id_inst_n;
   assign if_ready = ~sk_valid;
   assign accept = if_valid & if_ready;
   // stall only holds a real instruction; an empty slot keeps filling
   assign hold = if_id_stall & id_valid;
   always_comb begin
      sk_load    = ~id_flush & hold & accept;
      sk_clr     = id_flush | (~hold & sk_valid);
      id_valid_n = id_flush ? 1'b0 : hold ? 1'b1 : (sk_valid | accept);
      id_pc_n    = (id_flush | hold) ? id_pc : sk_valid ? sk_q.pc : accept ? if_pc : id_pc;
      id_inst_n  = id_flush ? NOP_INST : hold ? id_inst : sk_valid ? sk_q.inst : accept ? if_inst : NOP_INST;
   end
   pipe_skid_entry #(.W($bits(fetch_t))) u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (sk_load),
      .clr   (sk_clr),
      .d     ({if_pc, if_inst}),
      .valid (sk_valid),
      .q     (sk_q)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         id_valid <= 1'b0;
         id_pc    <= '0;
         id_inst  <= NOP_INST;
      end else begin
         id_valid <= id_valid_n;
         id_pc    <= id_pc_n;
         id_inst  <= id_inst_n;
      end
`ifdef IF_ID_PERF_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (if_id_stall & id_valid & ~id_flush & ~&perf_stall_cnt)
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (id_flush & (id_valid | sk_valid) & ~&perf_flush_cnt)
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
`endif
endmodule
